relation_integrator: RTL and testbench
======================================

// Module: relation_integrator
// PURPOSE
// - Downstream of the monopulse stage. Consumes the unsigned |error|*|reference| product.
// - Integrates the product over a fixed window of N = 2**LOG2_N accepted samples.
// - Emits the window mean, plus a threshold flag that the AGC gain-control logic uses.
// - One result per window. Windows do not overlap. Integration is gated by an enable.
// PARAMETERS
// DATA_SIZE  64  width of i_relation, i_threshold and o_average
// LOG2_N     4   log2 of window length (N = 16); legal range 1..8
// PORTS
// i_clock      in   1          single clock; everything changes on its rising edge
// i_reset      in   1          synchronous, active-high reset
// i_enable     in   1          1 = integrate; 0 = abort the current window and go idle
// i_valid      in   1          i_relation is a valid sample this cycle
// i_relation   in   DATA_SIZE  unsigned product from the monopulse stage
// i_threshold  in   DATA_SIZE  unsigned compare level for o_above
// o_average    out  DATA_SIZE  floor(sum of N samples / N); held between results
// o_above      out  1          (o_average > i_threshold), sampled when o_average loads; held
// o_valid      out  1          one-cycle pulse: o_average and o_above updated
// o_dropped    out  1          one-cycle pulse: a valid sample was discarded in DUMP
// BEHAVIOUR
// - Reset: all outputs 0, accumulator 0, count 0, state IDLE.
//   Reset takes priority over every other event, including mid-window; the partial sum is lost.
// - Accumulator width is DATA_SIZE+LOG2_N, so it cannot overflow.
//   o_average = acc[DATA_SIZE+LOG2_N-1 : LOG2_N], i.e. truncation with no rounding.
// - Sample counter width is LOG2_N bits.
// - States: IDLE, ACCUM, DUMP.
// - IDLE
//   - acc = 0, count = 0; i_valid is ignored.
//   - i_enable = 1 -> ACCUM. The first sample is accepted on the following cycle.
// - ACCUM
//   - i_enable = 0 -> IDLE. acc and count clear, no o_valid, outputs hold.
//     This check has priority over a simultaneous i_valid.
//   - i_valid = 1 and count < N-1: acc += i_relation, count++.
//   - i_valid = 1 and count == N-1: acc += i_relation, state -> DUMP.
//   - i_valid = 0: hold.
// - DUMP (exactly one cycle)
//   - Load o_average and o_above from the full sum.
//   - o_valid = 1 in the next cycle only.
//   - Clear acc and count.
//   - Next state: ACCUM if i_enable, else IDLE.
//   - i_valid = 1 in DUMP: the sample is discarded and o_dropped pulses one cycle later.
//     It is not counted in either window.
// - Latency: the Nth sample is presented in cycle k; o_valid is high in cycle k+2.
//   Back-to-back windows lose exactly one sample slot (the DUMP cycle).
// - o_above uses i_threshold as sampled in the DUMP cycle. Later changes to the threshold do
//   not alter the held flag.
// - o_valid and o_dropped are never high for more than one consecutive cycle.
// TESTING (DATA_SIZE=8, LOG2_N=2, N=4)
// 1. Reset
//    - Assert i_reset 3 cycles with random inputs -> all outputs 0.
//    - Deassert with i_enable=0 -> no o_valid.
// 2. Basic window
//    - Stimulus: enable; i_relation 10,20,30,40 on consecutive valid cycles; i_threshold=24.
//    - Response: o_average=25, o_above=1, o_valid one cycle, 2 cycles after the 40.
// 3. Full-scale samples
//    - Stimulus: 255 x4.
//    - Response: o_average=255 (sum 1020 held without overflow).
//    - Stimulus: 1,1,1,2.
//    - Response: o_average=1 (truncation).
// 4. Gapped valid
//    - Stimulus: the samples of test 2 separated by 0..3 idle cycles.
//    - Response: the same result.
//    - i_threshold=25 -> o_above=0 (strict compare).
// 5. Abort and reset mid-window
//    - Stimulus: 2 samples, drop i_enable, re-enable, then 4,4,4,4.
//    - Response: a single o_valid, o_average=4.
//    - Stimulus: i_reset after 3 samples.
//    - Response: no o_valid; the next window starts from zero.
// 6. Sample during DUMP
//    - Stimulus: valid every cycle with samples 8 x4, then 100, then 8 x4.
//    - Response: the 100 lands in DUMP, so o_dropped pulses once.
//    - Both windows give o_average=8.

Source files
------------

// File: rtl/relation_integrator.sv
// relation_integrator: windowed mean of the monopulse |error|*|reference| product with a threshold flag
// Non-overlapping windows of 2**LOG2_N accepted samples; one DUMP cycle per window drops any sample it sees.
module relation_integrator #(
    parameter int DATA_SIZE = 64,
    parameter int LOG2_N    = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_valid,
    input  logic [DATA_SIZE-1:0] i_relation,
    input  logic [DATA_SIZE-1:0] i_threshold,
    output logic [DATA_SIZE-1:0] o_average,
    output logic                 o_above,
    output logic                 o_valid,
    output logic                 o_dropped
);
    typedef enum logic [1:0] {IDLE, ACCUM, DUMP} state_t;

    state_t state, state_next;
    logic [DATA_SIZE+LOG2_N-1:0] acc;
    logic [LOG2_N-1:0] count;
    logic [DATA_SIZE-1:0] mean;

    assign mean = acc[DATA_SIZE+LOG2_N-1:LOG2_N];

    always_ff @(posedge i_clock)
        state <= i_reset ? IDLE : state_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = i_enable ? ACCUM : IDLE;
            ACCUM:   state_next = !i_enable ? IDLE : (i_valid && &count) ? DUMP : ACCUM;
            default: state_next = i_enable ? ACCUM : IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            acc       <= '0;
            count     <= '0;
            o_average <= '0;
            o_above   <= 1'b0;
            o_valid   <= 1'b0;
            o_dropped <= 1'b0;
        end else begin
            o_valid   <= state == DUMP;
            o_dropped <= state == DUMP && i_valid;
            if (state == ACCUM && i_enable) begin
                if (i_valid) begin
                    acc   <= acc + {{LOG2_N{1'b0}}, i_relation};
                    count <= count + 1'b1;
                end
            end else begin
                acc   <= '0;
                count <= '0;
            end
            if (state == DUMP) begin
                o_average <= mean;
                o_above   <= mean > i_threshold;
            end
        end
    end
endmodule

// File: tb/tb_relation_integrator.sv
// tb_relation_integrator: directed table-driven check of relation_integrator (DATA_SIZE=8, N=4)
// Each table row is one cycle: inputs applied, then outputs expected right after the following edge.
module tb_relation_integrator;
    logic       clk = 1'b0;
    logic       rst, en, vld, above, ov, drop;
    logic [7:0] rel, thr, avg;
    int         errors = 0;
    int         checks = 0;

    typedef struct {
        logic       en;
        logic       vld;
        logic [7:0] rel;
        logic [7:0] thr;
        logic [7:0] avg;
        logic       above;
        logic       ov;
        logic       drop;
    } vec_t;

    vec_t tbl[$];

    relation_integrator #(.DATA_SIZE(8), .LOG2_N(2)) dut (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_valid(vld),
        .i_relation(rel), .i_threshold(thr),
        .o_average(avg), .o_above(above), .o_valid(ov), .o_dropped(drop)
    );

    always #5 clk = ~clk;

    function automatic void v(input logic e, input logic vl, input logic [7:0] r, input logic [7:0] t,
                              input logic [7:0] a, input logic ab, input logic o, input logic d);
        tbl.push_back('{e, vl, r, t, a, ab, o, d});
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; vld = 1'b0; rel = '0; thr = '0;
        // reset with random inputs
        for (int i = 0; i < 3; i++) begin
            en = 1'($urandom); vld = 1'($urandom);
            rel = 8'($urandom); thr = 8'($urandom);
            step();
            chk($sformatf("reset%0d avg", i), avg, 8'd0);
            chk($sformatf("reset%0d above", i), {7'd0, above}, 8'd0);
            chk($sformatf("reset%0d valid", i), {7'd0, ov}, 8'd0);
            chk($sformatf("reset%0d dropped", i), {7'd0, drop}, 8'd0);
        end
        rst = 1'b0; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vld = 1'b1; rel = 8'($urandom);
            step();
            chk($sformatf("idle%0d valid", i), {7'd0, ov}, 8'd0);
            chk($sformatf("idle%0d avg", i), avg, 8'd0);
        end

        // basic window: 10,20,30,40 -> 25
        v(1, 0, 0, 24, 0, 0, 0, 0);
        v(1, 1, 10, 24, 0, 0, 0, 0);
        v(1, 1, 20, 24, 0, 0, 0, 0);
        v(1, 1, 30, 24, 0, 0, 0, 0);
        v(1, 1, 40, 24, 0, 0, 0, 0);
        v(1, 0, 0, 24, 25, 1, 1, 0);
        // full scale, then truncation
        for (int i = 0; i < 4; i++) v(1, 1, 255, 24, 25, 1, 0, 0);
        v(1, 0, 0, 24, 255, 1, 1, 0);
        for (int i = 0; i < 3; i++) v(1, 1, 1, 1, 255, 1, 0, 0);
        v(1, 1, 2, 1, 255, 1, 0, 0);
        v(1, 0, 0, 1, 1, 0, 1, 0);
        // sample during DUMP is dropped
        for (int i = 0; i < 4; i++) v(1, 1, 8, 7, 1, 0, 0, 0);
        v(1, 1, 100, 7, 8, 1, 1, 1);
        for (int i = 0; i < 4; i++) v(1, 1, 8, 7, 8, 1, 0, 0);
        v(1, 0, 0, 7, 8, 1, 1, 0);
        // gapped valid, strict compare, held flag
        v(1, 1, 10, 25, 8, 1, 0, 0);
        v(1, 0, 99, 25, 8, 1, 0, 0);
        v(1, 1, 20, 25, 8, 1, 0, 0);
        for (int i = 0; i < 2; i++) v(1, 0, 99, 25, 8, 1, 0, 0);
        v(1, 1, 30, 25, 8, 1, 0, 0);
        for (int i = 0; i < 3; i++) v(1, 0, 99, 25, 8, 1, 0, 0);
        v(1, 1, 40, 25, 8, 1, 0, 0);
        v(1, 0, 0, 25, 25, 0, 1, 0);
        v(1, 0, 0, 0, 25, 0, 0, 0);
        // abort mid-window, re-enable
        v(1, 1, 50, 0, 25, 0, 0, 0);
        v(1, 1, 50, 0, 25, 0, 0, 0);
        v(0, 1, 50, 0, 25, 0, 0, 0);
        v(1, 1, 77, 0, 25, 0, 0, 0);
        for (int i = 0; i < 4; i++) v(1, 1, 4, 0, 25, 0, 0, 0);
        v(1, 0, 0, 0, 4, 1, 1, 0);
        v(0, 1, 9, 0, 4, 1, 0, 0);
        v(0, 1, 9, 0, 4, 1, 0, 0);

        foreach (tbl[i]) begin
            en = tbl[i].en; vld = tbl[i].vld; rel = tbl[i].rel; thr = tbl[i].thr;
            step();
            chk($sformatf("vec%0d avg", i), avg, tbl[i].avg);
            chk($sformatf("vec%0d above", i), {7'd0, above}, {7'd0, tbl[i].above});
            chk($sformatf("vec%0d valid", i), {7'd0, ov}, {7'd0, tbl[i].ov});
            chk($sformatf("vec%0d dropped", i), {7'd0, drop}, {7'd0, tbl[i].drop});
        end

        // reset mid-window loses the partial sum
        en = 1'b1; vld = 1'b0; thr = 8'd11;
        step();
        vld = 1'b1; rel = 8'd200;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        step();
        chk("midreset avg", avg, 8'd0);
        chk("midreset above", {7'd0, above}, 8'd0);
        chk("midreset valid", {7'd0, ov}, 8'd0);
        rst = 1'b0; vld = 1'b0;
        step();
        vld = 1'b1; rel = 8'd12;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("post_reset%0d valid", i), {7'd0, ov}, 8'd0);
        end
        vld = 1'b0;
        step();
        chk("post_reset avg", avg, 8'd12);
        chk("post_reset above", {7'd0, above}, 8'd1);
        chk("post_reset valid", {7'd0, ov}, 8'd1);
        step();
        chk("post_reset pulse", {7'd0, ov}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
